branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Parametrised multi-cycle micro-sequencer for the control-flow opcode family: JR s8, JP a16 and CALL a16, unconditional or conditional. It sits in the control unit beside the per-opcode microcode blocks. Unlike them, it owns its own M-cycle and T-step counters, so it needs no external cycle bookkeeping. It latches the branch condition at dispatch, emits one-hot datapath strobes, and hands control back through a single o_IR_Fetch pulse.

## Interface
- STEPS, 4: T-steps per M-cycle, legal range 2..8.
- COND_W, 4: width of the condition-select and flag-condition vectors.
- i_Clk  in  1  system clock; all state updates on the rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Start  in  1  dispatch pulse from the decoder; sampled only in IDLE.
- i_Mode  in  2  operation: 00 JR, 01 JP, 10 CALL, 11 reserved.
- i_Y  in  COND_W  one-hot condition select from the opcode.
- i_Conditions  in  COND_W  current flag conditions (NZ, Z, NC, C).
- i_Always  in  1  unconditional form.
- o_Busy  out  1  sequence in progress.
- o_Cycle  out  3  current M-cycle index, starting at 0.
- o_Step  out  STEPS  one-hot T-step.
- o_Address_Out  out  1  drive the address bus.
- o_Addr_Sel  out  1  address source: 0 = PC, 1 = SP.
- o_Bus_In  out  1  capture the data bus.
- o_Bus_Out  out  1  drive the data bus.
- o_Data_Sel  out  1  write source: 0 = PCH, 1 = PCL.
- o_Load_Z  out  1  load Z from the bus.
- o_Load_W  out  1  load W from the bus.
- o_PC_Inc  out  1  increment PC.
- o_SP_Dec  out  1  decrement SP.
- o_PC_Add_Z  out  1  PC <= PC + sign-extended Z.
- o_PC_Load_WZ  out  1  PC <= {W, Z}.
- o_IR_Fetch  out  1  return control to opcode fetch.
- o_Error  out  1  one-cycle pulse when the reserved mode is dispatched.

## Operation
- Internal state:
  - FSM with states IDLE and RUN.
  - Step ring, one-hot, width STEPS.
  - 3-bit M-cycle counter.
  - Latched mode.
  - Latched condition flag `taken`.
- Condition evaluation:
  - `taken = (|(i_Y & i_Conditions)) | i_Always`.
  - The reduction-OR is applied to the AND result. Precedence is explicit.
  - `taken` is latched on the dispatch edge only; flag changes afterwards have no effect.
- Dispatch from IDLE:
  - If i_Start = 1 and i_Mode is not 11: enter RUN with step = 0, cycle = 0.
  - If i_Mode = 11: stay in IDLE and pulse o_Error.
- Sequence termination:
  - The final M-cycle is chosen by mode and `taken`.
  - On its last step, o_IR_Fetch = 1 for that one clock, then the block returns to IDLE.
- JR (2 M-cycles taken, 1 not taken):
  - M0: step0 Address_Out with Addr_Sel = 0 and PC_Inc; step1 Bus_In + Load_Z.
  - M1: step1 PC_Add_Z.
- JP (3 M-cycles taken, 2 not taken):
  - M0: read into Z, as for JR.
  - M1: read into W, same pattern.
  - M2: step1 PC_Load_WZ.
- CALL (5 M-cycles taken, 2 not taken):
  - M0 and M1: as for JP.
  - M2: step1 SP_Dec.
  - M3: step0 Address_Out with Addr_Sel = 1; step1 Bus_Out with Data_Sel = 0, then SP_Dec.
  - M4: step0 Address_Out with Addr_Sel = 1; step1 Bus_Out with Data_Sel = 1 and PC_Load_WZ.
- All strobes are decoded combinationally from the registered state. Every strobe is 0 in IDLE.

## Timing
- Reset: every output is 0, including o_Busy, o_Cycle = 0 and o_Step = 0; the FSM is in IDLE.
- Reset mid-sequence: abort immediately; no further strobes are issued.
- Dispatch latency: the first RUN step (o_Step[0]) appears in the clock after the i_Start edge.
- Step ring rotates once per clock in RUN. o_Cycle increments when step[STEPS-1] is active.
- o_Busy is 1 for every RUN clock, including the clock that carries o_IR_Fetch.
- Total busy clocks = M × STEPS, where M is the M-cycle count for the mode/taken case above.
- Back-to-back dispatch: i_Start asserted in the o_IR_Fetch clock is ignored. A new dispatch is accepted from the next clock (IDLE).
- i_Start while in RUN: ignored; latched values are unchanged.
- o_Error fires in the clock after the reserved dispatch and never coincides with o_Busy.
- The M-cycle counter does not wrap: the longest sequence ends at cycle 4.

## Test plan
- JR, i_Always = 1, STEPS = 4:
  - o_Busy for exactly 8 clocks.
  - Load_Z at cycle 0 step 1; PC_Add_Z at cycle 1 step 1.
  - o_IR_Fetch in clock 8 only.
- JR conditional, i_Y = 0100, i_Conditions = 0010 (not taken):
  - 4 busy clocks; no PC_Add_Z.
  - i_Conditions switched to 0100 after dispatch does not change the result.
- CALL taken, i_Y = 0001, i_Conditions = 0001:
  - 20 busy clocks.
  - SP_Dec at cycles 2 and 3; Bus_Out with Data_Sel 0 then 1; PC_Load_WZ at cycle 4 step 1.
- JP not taken, then i_Start held through the o_IR_Fetch clock:
  - Second dispatch is ignored until IDLE, then accepted.
  - The second run is a full 12 clocks when taken.
- i_Mode = 11: o_Error pulses once; o_Busy stays 0.
- Assert i_Rst_n = 0 at CALL cycle 3 step 1: all outputs drop to 0 asynchronously; after release, IDLE accepts a JR normally. Repeat the JR check with STEPS = 2: 4 busy clocks.

Source files
------------

// File: rtl/branch_sequencer.sv
// Self-timed micro-sequencer for JR s8 / JP a16 / CALL a16 with its own M-cycle
// and T-step counters; strobes are decoded from the registered sequencing state.
module branch_sequencer #(
    parameter int STEPS  = 4,
    parameter int COND_W = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Start,
    input  logic [1:0]        i_Mode,
    input  logic [COND_W-1:0] i_Y,
    input  logic [COND_W-1:0] i_Conditions,
    input  logic              i_Always,
    output logic              o_Busy,
    output logic [2:0]        o_Cycle,
    output logic [STEPS-1:0]  o_Step,
    output logic              o_Address_Out,
    output logic              o_Addr_Sel,
    output logic              o_Bus_In,
    output logic              o_Bus_Out,
    output logic              o_Data_Sel,
    output logic              o_Load_Z,
    output logic              o_Load_W,
    output logic              o_PC_Inc,
    output logic              o_SP_Dec,
    output logic              o_PC_Add_Z,
    output logic              o_PC_Load_WZ,
    output logic              o_IR_Fetch,
    output logic              o_Error
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] MODE_JR   = 2'b00;
    localparam logic [1:0] MODE_JP   = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [STEPS-1:0] STEP_NONE  = {STEPS{1'b0}};
    localparam logic [STEPS-1:0] STEP_FIRST = {{(STEPS-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [STEPS-1:0] r_step;
    logic [2:0]       r_cycle;
    logic [1:0]       r_mode;
    logic             r_taken;
    logic             r_error;

    logic       w_taken;
    logic       w_last_step;
    logic       w_done;
    logic [2:0] w_final_cycle;
    logic       w_s0;
    logic       w_s1;
    logic       w_address_out, w_addr_sel, w_bus_in, w_bus_out, w_data_sel;
    logic       w_load_z, w_load_w, w_pc_inc, w_sp_dec, w_pc_add_z, w_pc_load_wz;

    assign w_taken     = (|(i_Y & i_Conditions)) | i_Always;
    assign w_last_step = r_step[STEPS-1];
    assign w_s0        = r_step[0];
    assign w_s1        = r_step[1];
    assign w_done      = (r_state == ST_RUN) && w_last_step && (r_cycle == w_final_cycle);

    // Last M-cycle of the latched mode, shortened when the condition failed
    always_comb begin
        w_final_cycle = 3'd0;
        case (r_mode)
            MODE_JR:   w_final_cycle = r_taken ? 3'd1 : 3'd0;
            MODE_JP:   w_final_cycle = r_taken ? 3'd2 : 3'd1;
            MODE_CALL: w_final_cycle = r_taken ? 3'd4 : 3'd1;
            default:   w_final_cycle = 3'd0;
        endcase
    end

    // Sequencing state: dispatch, step ring rotation, M-cycle advance, completion
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= STEP_NONE;
            r_cycle <= 3'd0;
            r_mode  <= MODE_JR;
            r_taken <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_Start && (i_Mode == MODE_RSVD)) begin
                        r_error <= 1'b1;
                    end else if (i_Start) begin
                        r_state <= ST_RUN;
                        r_step  <= STEP_FIRST;
                        r_cycle <= 3'd0;
                        r_mode  <= i_Mode;
                        r_taken <= w_taken;
                    end
                end
                ST_RUN: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_step  <= STEP_NONE;
                        r_cycle <= 3'd0;
                    end else if (w_last_step) begin
                        r_step  <= STEP_FIRST;
                        r_cycle <= r_cycle + 3'd1;
                    end else begin
                        r_step  <= {r_step[STEPS-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_step  <= STEP_NONE;
                    r_cycle <= 3'd0;
                end
            endcase
        end
    end

    // Datapath strobes per (mode, M-cycle, T-step); all quiet outside RUN
    always_comb begin
        w_address_out = 1'b0;
        w_addr_sel    = 1'b0;
        w_bus_in      = 1'b0;
        w_bus_out     = 1'b0;
        w_data_sel    = 1'b0;
        w_load_z      = 1'b0;
        w_load_w      = 1'b0;
        w_pc_inc      = 1'b0;
        w_sp_dec      = 1'b0;
        w_pc_add_z    = 1'b0;
        w_pc_load_wz  = 1'b0;
        if (r_state == ST_RUN) begin
            case (r_cycle)
                3'd0: begin
                    w_address_out = w_s0;
                    w_pc_inc      = w_s0;
                    w_bus_in      = w_s1;
                    w_load_z      = w_s1;
                end
                3'd1: begin
                    if (r_mode == MODE_JR) begin
                        w_pc_add_z    = w_s1;
                    end else begin
                        w_address_out = w_s0;
                        w_pc_inc      = w_s0;
                        w_bus_in      = w_s1;
                        w_load_w      = w_s1;
                    end
                end
                3'd2: begin
                    if (r_mode == MODE_JP) begin
                        w_pc_load_wz = w_s1;
                    end else if (r_mode == MODE_CALL) begin
                        w_sp_dec     = w_s1;
                    end else begin
                        w_pc_load_wz = 1'b0;
                    end
                end
                // Push PCH then PCL through SP; SP steps down after the high byte
                3'd3: begin
                    w_address_out = w_s0;
                    w_addr_sel    = w_s0;
                    w_bus_out     = w_s1;
                    w_sp_dec      = w_s1;
                end
                3'd4: begin
                    w_address_out = w_s0;
                    w_addr_sel    = w_s0;
                    w_bus_out     = w_s1;
                    w_data_sel    = w_s1;
                    w_pc_load_wz  = w_s1;
                end
                default: begin
                    w_address_out = 1'b0;
                end
            endcase
        end else begin
            w_address_out = 1'b0;
        end
    end

    assign o_Busy        = (r_state == ST_RUN);
    assign o_Cycle       = r_cycle;
    assign o_Step        = r_step;
    assign o_Address_Out = w_address_out;
    assign o_Addr_Sel    = w_addr_sel;
    assign o_Bus_In      = w_bus_in;
    assign o_Bus_Out     = w_bus_out;
    assign o_Data_Sel    = w_data_sel;
    assign o_Load_Z      = w_load_z;
    assign o_Load_W      = w_load_w;
    assign o_PC_Inc      = w_pc_inc;
    assign o_SP_Dec      = w_sp_dec;
    assign o_PC_Add_Z    = w_pc_add_z;
    assign o_PC_Load_WZ  = w_pc_load_wz;
    assign o_IR_Fetch    = w_done;
    assign o_Error       = r_error;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed plan steps plus randomized dispatches,
// compared clock by clock against a micro-program reference model.
module tb_branch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] y = 4'd0;
    logic [3:0] cond = 4'd0;
    logic       alw = 1'b0;

    int checks = 0;
    int errors = 0;

    logic       busy1, aout1, asel1, bin1, bout1, dsel1, lz1, lw1, pci1, spd1, paz1, plw1, irf1, err1;
    logic [2:0] cyc1;
    logic [3:0] step1;
    logic       busy2, aout2, asel2, bin2, bout2, dsel2, lz2, lw2, pci2, spd2, paz2, plw2, irf2, err2;
    logic [2:0] cyc2;
    logic [1:0] step2;

    always #5 clk = ~clk;

    branch_sequencer #(.STEPS(4), .COND_W(4)) u_dut4 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Mode(mode), .i_Y(y),
        .i_Conditions(cond), .i_Always(alw), .o_Busy(busy1), .o_Cycle(cyc1), .o_Step(step1),
        .o_Address_Out(aout1), .o_Addr_Sel(asel1), .o_Bus_In(bin1), .o_Bus_Out(bout1),
        .o_Data_Sel(dsel1), .o_Load_Z(lz1), .o_Load_W(lw1), .o_PC_Inc(pci1), .o_SP_Dec(spd1),
        .o_PC_Add_Z(paz1), .o_PC_Load_WZ(plw1), .o_IR_Fetch(irf1), .o_Error(err1)
    );

    branch_sequencer #(.STEPS(2), .COND_W(4)) u_dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start2), .i_Mode(mode), .i_Y(y),
        .i_Conditions(cond), .i_Always(alw), .o_Busy(busy2), .o_Cycle(cyc2), .o_Step(step2),
        .o_Address_Out(aout2), .o_Addr_Sel(asel2), .o_Bus_In(bin2), .o_Bus_Out(bout2),
        .o_Data_Sel(dsel2), .o_Load_Z(lz2), .o_Load_W(lw2), .o_PC_Inc(pci2), .o_SP_Dec(spd2),
        .o_PC_Add_Z(paz2), .o_PC_Load_WZ(plw2), .o_IR_Fetch(irf2), .o_Error(err2)
    );

    wire [24:0] obs1 = {busy1, cyc1, 4'b0000, step1, aout1, asel1, bin1, bout1, dsel1,
                        lz1, lw1, pci1, spd1, paz1, plw1, irf1, err1};
    wire [24:0] obs2 = {busy2, cyc2, 6'b000000, step2, aout2, asel2, bin2, bout2, dsel2,
                        lz2, lw2, pci2, spd2, paz2, plw2, irf2, err2};

    function automatic int n_mcycles(input logic [1:0] md, input bit tk);
        if (md == 2'b00) return tk ? 2 : 1;
        if (md == 2'b01) return tk ? 3 : 2;
        return tk ? 5 : 2;
    endfunction

    // Micro-programs: 0 read Z, 1 read W, 2 relative add, 3 load WZ, 4 SP dec, 5 push PCH, 6 push PCL
    function automatic int op_of(input logic [1:0] md, input int c);
        if (c == 0) return 0;
        if (md == 2'b00) return 2;
        if (c == 1) return 1;
        if (md == 2'b01) return 3;
        if (c == 2) return 4;
        if (c == 3) return 5;
        return 6;
    endfunction

    function automatic logic [24:0] exp_vec(input logic [1:0] md, input bit tk, input int k, input int steps);
        int total, c, s, op;
        logic ao, as, bi, bo, ds, lz, lw, pi, sd, paz, plw, irf;
        total = n_mcycles(md, tk) * steps;
        if (k >= total) return 25'd0;
        c = k / steps;
        s = k % steps;
        {ao, as, bi, bo, ds, lz, lw, pi, sd, paz, plw} = 11'd0;
        op = op_of(md, c);
        case (op)
            0, 1: begin
                if (s == 0) begin ao = 1'b1; pi = 1'b1; end
                else if (s == 1) begin bi = 1'b1; lz = (op == 0); lw = (op == 1); end
            end
            2: paz = (s == 1);
            3: plw = (s == 1);
            4: sd  = (s == 1);
            5: begin
                if (s == 0) begin ao = 1'b1; as = 1'b1; end
                else if (s == 1) begin bo = 1'b1; sd = 1'b1; end
            end
            default: begin
                if (s == 0) begin ao = 1'b1; as = 1'b1; end
                else if (s == 1) begin bo = 1'b1; ds = 1'b1; plw = 1'b1; end
            end
        endcase
        irf = (k == total - 1);
        return {1'b1, 3'(c), 8'(1 << s), ao, as, bi, bo, ds, lz, lw, pi, sd, paz, plw, irf, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] expv, input int k);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, obs, expv);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start2 = v;
        else start = v;
    endtask

    // Caller is at a negedge; the following posedge is the dispatch edge.
    // noise: 0 quiet (conditions switched to c_after), 1 random inputs, 2 i_Start held high
    task automatic dispatch(input int sel, input logic [1:0] md, input logic [3:0] yy,
                            input logic [3:0] cc, input logic aa, input logic [3:0] c_after,
                            input int noise, input string tag);
        bit tk;
        int total, steps;
        steps = (sel != 0) ? 2 : 4;
        tk = ((yy & cc) != 4'd0) || aa;
        mode = md; y = yy; cond = cc; alw = aa;
        start = (sel == 0); start2 = (sel != 0);
        @(negedge clk);
        if (md == 2'b11) begin
            check(tag, (sel != 0) ? obs2 : obs1, 25'd1, 0);
            start = 1'b0; start2 = 1'b0;
            @(negedge clk);
            check(tag, (sel != 0) ? obs2 : obs1, 25'd0, 1);
        end else begin
            total = n_mcycles(md, tk) * steps;
            for (int k = 0; k <= total; k++) begin
                if (k > 0) @(negedge clk);
                check(tag, (sel != 0) ? obs2 : obs1, exp_vec(md, tk, k, steps), k);
                if (k < total) begin
                    case (noise)
                        0: begin set_start(sel, 1'b0); cond = c_after; end
                        1: begin
                            set_start(sel, 1'($urandom_range(0, 1)));
                            mode = 2'($urandom_range(0, 3));
                            y    = 4'($urandom_range(0, 15));
                            cond = 4'($urandom_range(0, 15));
                            alw  = 1'($urandom_range(0, 1));
                        end
                        default: begin set_start(sel, 1'b1); cond = 4'($urandom_range(0, 15)); end
                    endcase
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset4", obs1, 25'd0, 0);
        check("reset2", obs2, 25'd0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        dispatch(0, 2'b00, 4'b0000, 4'b0000, 1'b1, 4'b0000, 0, "jr_always");
        dispatch(0, 2'b00, 4'b0100, 4'b0010, 1'b0, 4'b0100, 0, "jr_not_taken");
        dispatch(0, 2'b10, 4'b0001, 4'b0001, 1'b0, 4'b0000, 0, "call_taken");
        dispatch(0, 2'b01, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2, "jp_not_taken_hold");
        dispatch(0, 2'b01, 4'b0000, 4'b0000, 1'b1, 4'b0000, 0, "jp_taken_after_hold");
        dispatch(0, 2'b11, 4'b0000, 4'b0000, 1'b1, 4'b0000, 0, "reserved");

        // Abort a taken CALL at cycle 3 step 1 with an asynchronous reset
        mode = 2'b10; y = 4'b0001; cond = 4'b0001; alw = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(posedge clk);
        #1 check("call_c3s1", obs1, exp_vec(2'b10, 1'b1, 13, 4), 13);
        #2 rst_n = 1'b0;
        #1 check("async_reset", obs1, 25'd0, 0);
        @(negedge clk);
        check("reset_hold", obs1, 25'd0, 0);
        rst_n = 1'b1;
        dispatch(0, 2'b00, 4'b0000, 4'b0000, 1'b1, 4'b0000, 0, "jr_after_reset");
        dispatch(1, 2'b00, 4'b0000, 4'b0000, 1'b1, 4'b0000, 0, "jr_steps2");

        for (int i = 0; i < 40; i++) begin
            dispatch(($urandom_range(0, 3) == 0) ? 1 : 0,
                     2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                     4'($urandom_range(0, 15)), $urandom_range(0, 2), "random");
        end

        start = 1'b0; start2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("final_idle4", obs1, 25'd0, 0);
        check("final_idle2", obs2, 25'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
